cpu_ocimem_access_arbiter: RTL and testbench

//  Shares the CPU's single-port on-chip debug RAM (OCI memory) between two requesters:
//   - the JTAG debug host, via the sysclk-domain take_action strobes and jdo;
//   - the CPU's Avalon debug slave.

---
 rtl/cpu_ocimem_access_arbiter_pkg.sv | 33 +++
 rtl/cpu_ocimem_access_arbiter_if.sv | 26 ++
 rtl/cpu_ocimem_jtag_req_latch.sv | 110 +++++++++++
 rtl/cpu_ocimem_access_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_cpu_ocimem_access_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ocimem_access_arbiter_pkg.sv
// Shared types and jdo field offsets for the OCI memory access arbiter.
// Round-robin arbitration is selected with the OCIMEM_ROUND_ROBIN_EN macro.
package cpu_ocimem_access_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    J_ACC  = 3'd1,
    J_WAIT = 3'd2,
    A_ACC  = 3'd3,
    A_WAIT = 3'd4
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef enum logic {
    GRANT_JTAG   = 1'b0,
    GRANT_AVALON = 1'b1
  } grant_e;

  localparam int unsigned JDO_W         = 38;
  localparam int unsigned JDO_ADDR_LSB  = 17;
  localparam int unsigned JDO_WDATA_LSB = 3;
  localparam int unsigned JDO_WDATA_MSB = 34;

  // Wait-state preload so that *_WAIT lasts exactly ram_lat cycles.
  function automatic logic [1:0] lat_preload(input int unsigned ram_lat);
    return 2'(ram_lat - 1);
  endfunction

endpackage

// File: rtl/cpu_ocimem_access_arbiter_if.sv
// Avalon debug-slave and OCI RAM signal bundle; the arbiter is the slave side.
interface cpu_ocimem_access_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0] av_address;
  logic              av_read;
  logic              av_write;
  logic [DATA_W-1:0] av_writedata;
  logic [DATA_W-1:0] av_readdata;
  logic              av_waitrequest;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  av_address, av_read, av_write, av_writedata, ram_rdata,
    output av_readdata, av_waitrequest, ram_addr, ram_wr, ram_wdata
  );

  modport master (
    output av_address, av_read, av_write, av_writedata, ram_rdata,
    input  av_readdata, av_waitrequest, ram_addr, ram_wr, ram_wdata
  );
endinterface

// File: rtl/cpu_ocimem_jtag_req_latch.sv
// JTAG front end: decodes take_action strobes into a one-deep pending request,
// owns the auto-incrementing JTAG address and the sticky overrun flag.
module cpu_ocimem_jtag_req_latch
  import cpu_ocimem_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a_i,
  input  logic              take_action_ocimem_b_i,
  input  logic              take_no_action_ocimem_a_i,
  input  logic [JDO_W-1:0]  jdo_i,
  input  logic              done_i,
  output logic              accept_o,
  output logic              pend_o,
  output op_e               op_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              monitor_error_o
);

  logic              pend_q,  pend_d;
  op_e               op_q,    op_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              inc_q,   inc_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic              err_q,   err_d;

  logic any_strobe;
  logic drop;
  logic unused_jdo;

  assign any_strobe = take_action_ocimem_a_i | take_action_ocimem_b_i |
                      take_no_action_ocimem_a_i;
  assign accept_o   = any_strobe & ~pend_q;
  assign drop       = any_strobe & pend_q;
  assign unused_jdo = ^{jdo_i[JDO_W-1:JDO_WDATA_MSB+1], jdo_i[JDO_WDATA_LSB-1:0]};

  always_comb begin
    pend_d  = pend_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    inc_d   = inc_q;
    jaddr_d = jaddr_q;
    err_d   = err_q;

    // pend_q stays set through execution, so accept and done never coincide.
    if (accept_o) begin
      pend_d = 1'b1;
      if (take_action_ocimem_a_i) begin
        op_d    = OP_READ;
        addr_d  = jdo_i[JDO_ADDR_LSB +: ADDR_W];
        jaddr_d = jdo_i[JDO_ADDR_LSB +: ADDR_W];
        inc_d   = 1'b0;
      end else if (take_no_action_ocimem_a_i) begin
        op_d   = OP_READ;
        addr_d = jaddr_q;
        inc_d  = 1'b1;
      end else begin
        op_d    = OP_WRITE;
        addr_d  = jaddr_q;
        wdata_d = jdo_i[JDO_WDATA_MSB:JDO_WDATA_LSB];
        inc_d   = 1'b1;
      end
    end else if (done_i) begin
      pend_d = 1'b0;
      if (inc_q) begin
        jaddr_d = jaddr_q + ADDR_W'(1);
      end
    end

    // A dropped take_action_ocimem_a sets the flag even though it would clear it.
    if (take_action_ocimem_a_i) begin
      err_d = 1'b0;
    end
    if (drop) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q  <= 1'b0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      inc_q   <= 1'b0;
      jaddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      inc_q   <= inc_d;
      jaddr_q <= jaddr_d;
      err_q   <= err_d;
    end
  end

  assign pend_o          = pend_q;
  assign op_o            = op_q;
  assign addr_o          = addr_q;
  assign wdata_o         = wdata_q;
  assign monitor_error_o = err_q;

endmodule

// File: rtl/cpu_ocimem_access_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG and the Avalon debug slave.
// OCIMEM_ROUND_ROBIN_EN selects round-robin arbitration; otherwise JTAG has fixed priority.
module cpu_ocimem_access_arbiter
  import cpu_ocimem_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         take_action_ocimem_a,
  input  logic                         take_action_ocimem_b,
  input  logic                         take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]             jdo,
  cpu_ocimem_access_arbiter_if.slave   bus,
  output logic [DATA_W-1:0]            MonDReg,
  output logic                         monitor_ready,
  output logic                         monitor_error
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mon_dreg_q;
  logic              mon_ready_q;
  logic [DATA_W-1:0] av_rdata_q;
  logic              av_wait_q;

  logic              j_accept;
  logic              j_pend;
  op_e               j_op;
  logic [ADDR_W-1:0] j_addr;
  logic [31:0]       j_wdata;
  logic              j_done;
  logic              a_done;
  logic              a_req;
  logic              prefer_j;

  logic [ADDR_W-1:0] ram_addr_c;
  logic              ram_wr_c;
  logic [DATA_W-1:0] ram_wdata_c;

  cpu_ocimem_jtag_req_latch #(
    .ADDR_W (ADDR_W)
  ) u_jtag_req_latch (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .take_action_ocimem_a_i    (take_action_ocimem_a),
    .take_action_ocimem_b_i    (take_action_ocimem_b),
    .take_no_action_ocimem_a_i (take_no_action_ocimem_a),
    .jdo_i                     (jdo),
    .done_i                    (j_done),
    .accept_o                  (j_accept),
    .pend_o                    (j_pend),
    .op_o                      (j_op),
    .addr_o                    (j_addr),
    .wdata_o                   (j_wdata),
    .monitor_error_o           (monitor_error)
  );

  // The acknowledge cycle (waitrequest low) masks the still-asserted strobe.
  assign a_req = (bus.av_read | bus.av_write) & av_wait_q;

`ifdef OCIMEM_ROUND_ROBIN_EN
  grant_e last_grant_q, last_grant_d;

  assign prefer_j = (last_grant_q == GRANT_AVALON);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GRANT_AVALON;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign prefer_j = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_addr_c  = '0;
    ram_wr_c    = 1'b0;
    ram_wdata_c = '0;
    j_done      = 1'b0;
    a_done      = 1'b0;
`ifdef OCIMEM_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (j_pend && (prefer_j || !a_req)) begin
          state_d = J_ACC;
`ifdef OCIMEM_ROUND_ROBIN_EN
          last_grant_d = GRANT_JTAG;
`endif
        end else if (a_req) begin
          state_d = A_ACC;
`ifdef OCIMEM_ROUND_ROBIN_EN
          last_grant_d = GRANT_AVALON;
`endif
        end
      end
      J_ACC: begin
        ram_addr_c = j_addr;
        if (j_op == OP_WRITE) begin
          ram_wr_c    = 1'b1;
          ram_wdata_c = j_wdata;
          j_done      = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d   = lat_preload(RAM_LAT);
          state_d = J_WAIT;
        end
      end
      J_WAIT: begin
        ram_addr_c = j_addr;
        if (cnt_q == '0) begin
          j_done  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      A_ACC: begin
        ram_addr_c = bus.av_address;
        if (bus.av_write) begin
          ram_wr_c    = 1'b1;
          ram_wdata_c = bus.av_writedata;
          a_done      = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d   = lat_preload(RAM_LAT);
          state_d = A_WAIT;
        end
      end
      A_WAIT: begin
        ram_addr_c = bus.av_address;
        if (cnt_q == '0) begin
          a_done  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mon_dreg_q  <= '0;
      mon_ready_q <= 1'b1;
      av_rdata_q  <= '0;
      av_wait_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == J_WAIT && cnt_q == '0) begin
        mon_dreg_q <= bus.ram_rdata;
      end
      if (state_q == A_WAIT && cnt_q == '0) begin
        av_rdata_q <= bus.ram_rdata;
      end
      if (j_accept) begin
        mon_ready_q <= 1'b0;
      end else if (j_done) begin
        mon_ready_q <= 1'b1;
      end
      av_wait_q <= ~a_done;
    end
  end

  assign bus.ram_addr       = ram_addr_c;
  assign bus.ram_wr         = ram_wr_c;
  assign bus.ram_wdata      = ram_wdata_c;
  assign bus.av_readdata    = av_rdata_q;
  assign bus.av_waitrequest = av_wait_q;
  assign MonDReg            = mon_dreg_q;
  assign monitor_ready      = mon_ready_q;

endmodule

// File: tb/tb_cpu_ocimem_access_arbiter.sv
// Self-checking bench for cpu_ocimem_access_arbiter with a latency-accurate RAM
// and a word-level reference memory / JTAG address model.
module tb_cpu_ocimem_access_arbiter;

  localparam int LAT = 1;
`ifdef OCIMEM_ROUND_ROBIN_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ta_a = 1'b0, ta_b = 1'b0, tna_a = 1'b0;
  logic [37:0] jdo = '0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  always #5 clk = ~clk;

  cpu_ocimem_access_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  cpu_ocimem_access_arbiter #(.ADDR_W(8), .DATA_W(32), .RAM_LAT(LAT)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .jdo                     (jdo),
    .bus                     (bus),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // RAM: registered read with LAT cycles latency, preload port for the bench.
  logic [31:0] mem [256];
  logic [31:0] rd1, rd2;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
    rd1 <= mem[bus.ram_addr];
    rd2 <= rd1;
  end
  assign bus.ram_rdata = (LAT == 2) ? rd2 : rd1;

  logic [31:0] ref_mem [256];
  int unsigned ref_jaddr = 0;
  int tests_run = 0;
  int tests_failed = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic jtag_pulse(input int kind, input logic [7:0] a, input logic [31:0] wd);
    jdo = '0;
    jdo[34:3] = wd;
    if (kind == 0) jdo[24:17] = a;
    ta_a = (kind == 0); tna_a = (kind == 1); ta_b = (kind == 2);
    step();
    ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
  endtask

  task automatic wait_ready(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (monitor_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic av_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] rdata, output int lat, output bit ok);
    bus.av_address = a; bus.av_writedata = d;
    bus.av_write = wr; bus.av_read = !wr;
    lat = 0; ok = 1'b0; rdata = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      lat++;
      if (!bus.av_waitrequest) begin rdata = bus.av_readdata; ok = 1'b1; break; end
    end
    bus.av_read = 1'b0; bus.av_write = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    ref_jaddr = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);
    tests_run++;
    if ({monitor_ready, bus.av_waitrequest, monitor_error, bus.ram_wr} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/wait/err/wr=%b required 1100",
               {monitor_ready, bus.av_waitrequest, monitor_error, bus.ram_wr});
    end
    tests_run++;
    if (MonDReg !== 32'h0 || bus.av_readdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got MonDReg=%h av_readdata=%h required 0", MonDReg, bus.av_readdata);
    end
    reset_n = 1'b1;
    step(); step();
    tests_run++;
    if ({monitor_ready, bus.av_waitrequest, bus.ram_wr, bus.ram_addr} !== {3'b110, 8'h00}) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got rdy=%b wait=%b wr=%b addr=%h", monitor_ready,
               bus.av_waitrequest, bus.ram_wr, bus.ram_addr);
    end
  endtask

  task automatic test_jtag_read();
    int lat; bit ok;
    preload(8'h10, 32'hCAFEF00D);
    jtag_pulse(0, 8'h10, $urandom);
    tests_run++;
    if (monitor_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL ready_drop: got %b required 0", monitor_ready);
    end
    wait_ready(lat, ok);
    ref_jaddr = 32'h10;
    tests_run++;
    if (!ok || lat != 2 + LAT) begin
      tests_failed++;
      $display("FAIL jtag_read_latency: got %0d (ok=%0b) required %0d", lat, ok, 2 + LAT);
    end
    tests_run++;
    if (MonDReg !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("FAIL jtag_read_data: got %h required cafef00d", MonDReg);
    end
  endtask

  task automatic test_jtag_write_wrap();
    int lat; bit ok;
    preload(8'h00, $urandom);
    jtag_pulse(0, 8'hFF, 32'h0);
    wait_ready(lat, ok);
    ref_jaddr = 255;
    jtag_pulse(2, 8'h00, 32'h12345678);
    wait_ready(lat, ok);
    tests_run++;
    if (!ok || lat != 2) begin
      tests_failed++;
      $display("FAIL jtag_write_latency: got %0d (ok=%0b) required 2", lat, ok);
    end
    ref_mem[255] = 32'h12345678;
    ref_jaddr = 0;
    tests_run++;
    if (mem[255] !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL jtag_write_ram: got %h required 12345678", mem[255]);
    end
    jtag_pulse(1, 8'h00, 32'h0);
    wait_ready(lat, ok);
    tests_run++;
    if (!ok || MonDReg !== ref_mem[0]) begin
      tests_failed++;
      $display("FAIL jaddr_wrap_read: got %h (ok=%0b) required %h", MonDReg, ok, ref_mem[0]);
    end
    ref_jaddr = 1;
  endtask

  task automatic test_arbitration();
    int lat, jc, ac; bit ok, exp_j_first;
    logic [7:0] aaddr; logic [31:0] adata, jexp;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      if (r > 0) begin
        jtag_pulse(1, 8'h00, 32'h0);
        wait_ready(lat, ok);
        tests_run++;
        if (!ok || MonDReg !== ref_mem[ref_jaddr]) begin
          tests_failed++;
          $display("FAIL arb_solo_read: got %h (ok=%0b) required %h", MonDReg, ok, ref_mem[ref_jaddr]);
        end
        ref_jaddr = (ref_jaddr + 1) % 256;
      end
      exp_j_first = (r == 0) ? 1'b1 : !RR_BUILD;
      jexp = ref_mem[ref_jaddr];
      aaddr = 8'($urandom_range(0, 255));
      jtag_pulse(1, 8'h00, 32'h0);
      bus.av_address = aaddr; bus.av_read = 1'b1;
      jc = -1; ac = -1; adata = '0;
      for (int i = 0; i < 30 && (jc < 0 || ac < 0); i++) begin
        step();
        if (monitor_ready && jc < 0) jc = i;
        if (!bus.av_waitrequest && ac < 0) begin
          ac = i; adata = bus.av_readdata; bus.av_read = 1'b0;
        end
      end
      bus.av_read = 1'b0;
      step();
      ref_jaddr = (ref_jaddr + 1) % 256;
      tests_run++;
      if (jc < 0 || ac < 0 || ((jc < ac) != exp_j_first)) begin
        tests_failed++;
        $display("FAIL arb_order_r%0d: got jtag_done=%0d avalon_done=%0d required jtag_first=%0b",
                 r, jc, ac, exp_j_first);
      end
      tests_run++;
      if (adata !== ref_mem[aaddr] || MonDReg !== jexp) begin
        tests_failed++;
        $display("FAIL arb_data_r%0d: got av=%h jtag=%h required av=%h jtag=%h",
                 r, adata, MonDReg, ref_mem[aaddr], jexp);
      end
    end
  endtask

  task automatic test_overrun();
    int lat; bit ok;
    logic [7:0] x;
    x = 8'($urandom_range(0, 255));
    jtag_pulse(0, x, 32'h0);
    jtag_pulse(1, 8'h00, 32'h0);
    tests_run++;
    if (monitor_error !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set: got %b required 1", monitor_error);
    end
    wait_ready(lat, ok);
    tests_run++;
    if (!ok || MonDReg !== ref_mem[x]) begin
      tests_failed++;
      $display("FAIL overrun_first_op: got %h (ok=%0b) required %h", MonDReg, ok, ref_mem[x]);
    end
    jtag_pulse(1, 8'h00, 32'h0);
    jtag_pulse(0, 8'($urandom_range(0, 255)), 32'h0);
    wait_ready(lat, ok);
    tests_run++;
    if (!ok || monitor_error !== 1'b1 || MonDReg !== ref_mem[x]) begin
      tests_failed++;
      $display("FAIL overrun_set_wins: got err=%b data=%h required err=1 data=%h",
               monitor_error, MonDReg, ref_mem[x]);
    end
    ref_jaddr = (x + 1) % 256;
    x = 8'($urandom_range(0, 255));
    jtag_pulse(0, x, 32'h0);
    tests_run++;
    if (monitor_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clear: got %b required 0", monitor_error);
    end
    wait_ready(lat, ok);
    ref_jaddr = x;
  endtask

  task automatic test_random();
    int lat, kind, mism; bit ok;
    logic [7:0] a; logic [31:0] d, rdata;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      if (kind <= 2) begin
        jtag_pulse(kind, a, d);
        wait_ready(lat, ok);
        if (kind == 0) ref_jaddr = a;
        tests_run++;
        if (!ok || lat != ((kind == 2) ? 2 : 2 + LAT) ||
            (kind != 2 && MonDReg !== ref_mem[ref_jaddr])) begin
          tests_failed++;
          $display("FAIL rand_jtag_%0d kind=%0d: got data=%h lat=%0d required data=%h",
                   it, kind, MonDReg, lat, ref_mem[ref_jaddr]);
        end
        if (kind == 2) ref_mem[ref_jaddr] = d;
        if (kind != 0) ref_jaddr = (ref_jaddr + 1) % 256;
      end else begin
        av_xfer(kind == 4, a, d, rdata, lat, ok);
        tests_run++;
        if (!ok || lat != ((kind == 4) ? 2 : 2 + LAT) || (kind == 3 && rdata !== ref_mem[a])) begin
          tests_failed++;
          $display("FAIL rand_avalon_%0d kind=%0d: got data=%h lat=%0d required data=%h",
                   it, kind, rdata, lat, ref_mem[a]);
        end
        if (kind == 4) ref_mem[a] = d;
      end
    end
    mism = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
    tests_run++;
    if (mism != 0) begin
      tests_failed++;
      $display("FAIL ram_scan: got %0d mismatching words required 0", mism);
    end
  endtask

  task automatic test_reset_mid_access();
    bus.av_address = 8'h33; bus.av_writedata = ~ref_mem[8'h33]; bus.av_write = 1'b1;
    step();
    tests_run++;
    if (bus.ram_wr !== 1'b1 || bus.ram_addr !== 8'h33) begin
      tests_failed++;
      $display("FAIL a_acc_write: got wr=%b addr=%h required 1/33", bus.ram_wr, bus.ram_addr);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.ram_wr !== 1'b0 || bus.av_waitrequest !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_kills_write: got wr=%b wait=%b required 0/1", bus.ram_wr, bus.av_waitrequest);
    end
    bus.av_write = 1'b0;
    step(); step();
    tests_run++;
    if (mem[8'h33] !== ref_mem[8'h33]) begin
      tests_failed++;
      $display("FAIL reset_write_suppressed: got %h required %h", mem[8'h33], ref_mem[8'h33]);
    end
    reset_n = 1'b1;
    step();
    bus.av_address = 8'h44; bus.av_read = 1'b1;
    step(); step();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.av_waitrequest !== 1'b1 || bus.ram_addr !== 8'h00 || bus.ram_wr !== 1'b0 ||
        monitor_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_a_wait: got wait=%b addr=%h wr=%b rdy=%b required 1/00/0/1",
               bus.av_waitrequest, bus.ram_addr, bus.ram_wr, monitor_ready);
    end
    bus.av_read = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    ref_jaddr = 0;
  endtask

  initial begin
    bus.av_address = '0; bus.av_read = 1'b0; bus.av_write = 1'b0; bus.av_writedata = '0;
    test_reset();
    test_jtag_read();
    test_jtag_write_wrap();
    test_arbitration();
    test_overrun();
    test_random();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
